centrifugado_ejecutor: RTL and testbench
========================================

Name: centrifugado_ejecutor

Overview:
- Executes the spin phase of the wash cycle using the one-hot spin-time selection from the spin-time selector (iCentri_1..iCentri_4).
- Sequence: drains the drum, runs the spin motor for the selected duration, then reports completion.
- Sits between the selector/control FSM and the motor/valve LEDs and the display driver; timing comes from a 1 Hz enable tick.

Parameters:
- DRAIN_S, 10, drain duration in seconds before spin (1..511)
- T1_S, 150, spin duration for selection 1 (1..511)
- T2_S, 200, spin duration for selection 2 (1..511)
- T3_S, 275, spin duration for selection 3 (1..511)
- T4_S, 375, spin duration for selection 4 (1..511)

Ports:
- clk_in  input  1  system clock; the only clock
- iReset  input  1  synchronous, active-high reset
- iTick_1HZ  input  1  one-clk_in-cycle pulse, once per second
- iStart  input  1  start request, sampled only in IDLE
- iPausa  input  1  level; freezes countdown while high
- iHabilitar  input  1  level; spin mode enabled; low aborts a run
- iCentri_1..iCentri_4  input  1 each  one-hot spin-time selection
- iLed_Vaceando  output  1  drain valve active
- iLed_Motor  output  1  spin motor active
- iCentri_Activo  output  1  high from drain start through FIN
- iCentri_Fin  output  1  one-cycle completion pulse
- iSel_Error  output  1  one-cycle pulse: start rejected, bad selection
- iSegundos_Restantes  output  9  seconds remaining in current phase

Behaviour:
- All state changes occur on posedge clk_in. iReset=1 has priority over every other input and takes effect at the next edge:
  - state=IDLE
  - all 1-bit outputs 0
  - iSegundos_Restantes=0
  - latched duration=0
- FSM states: IDLE, VACIANDO, CENTRIFUGANDO, FIN.
- IDLE:
  - iStart=1, iHabilitar=1, selection exactly one-hot -> latch selected T*_S; next cycle state=VACIANDO, remaining=DRAIN_S.
  - iStart=1 with selection not one-hot (0000 or more than one bit) -> stay IDLE; iSel_Error=1 for one cycle.
  - iStart=1 with iHabilitar=0 -> ignored, no error.
- VACIANDO:
  - iLed_Vaceando=1, iLed_Motor=0.
  - On iTick_1HZ with iPausa=0: if remaining>1, decrement; if remaining==1, next state=CENTRIFUGANDO with remaining=latched duration.
- CENTRIFUGANDO:
  - iLed_Motor = !iPausa, iLed_Vaceando=0.
  - On tick with iPausa=0: if remaining>1, decrement; if remaining==1, next state=FIN with remaining=0.
- FIN:
  - Lasts exactly one cycle: iCentri_Fin=1, iCentri_Activo=1, LEDs 0.
  - Then IDLE.
- iCentri_Activo=1 in VACIANDO, CENTRIFUGANDO, FIN.
- Latency:
  - iStart to iCentri_Activo=1: 1 cycle.
  - Total run = DRAIN_S + T_sel ticks (excluding paused ticks), plus one FIN cycle.
- Boundary conditions:
  - Selection inputs are latched at start; changes mid-run are ignored.
  - iStart while not IDLE is ignored.
  - Tick coincident with iStart in IDLE is ignored (the count starts fresh).
  - Tick with iPausa=1 is dropped, not deferred.
  - iHabilitar=0 in any non-IDLE state -> IDLE at the next edge, outputs cleared, no iCentri_Fin pulse.
  - iReset and iHabilitar drop in the same cycle behave as reset.
  - Remaining never underflows; a count of 0 never occurs in VACIANDO or CENTRIFUGANDO.
  - All arithmetic is 9-bit unsigned; parameters above 511 are illegal.

Test Plan:
- Override DRAIN_S=3, T1_S=5; iCentri_1=1; pulse iStart; tick every 10 cycles -> 3 ticks of iLed_Vaceando (3,2,1), then 5 ticks of iLed_Motor (5..1), then one-cycle iCentri_Fin, then IDLE with iSegundos_Restantes=0.
- iCentri_3=1, default params; start; after drain, check iSegundos_Restantes=275; mid-run set iCentri_1=1 -> duration unchanged.
- Selections 0000 and 0110 with iStart -> iSel_Error pulse of one cycle, iCentri_Activo stays 0.
- During CENTRIFUGANDO at remaining=4, hold iPausa for 6 ticks -> remaining stays 4 and iLed_Motor=0; release -> countdown resumes at 4.
- Drop iHabilitar at remaining=2 in CENTRIFUGANDO -> IDLE next cycle, no iCentri_Fin; assert iReset mid-VACIANDO -> all outputs 0 next edge.
- In IDLE, assert iStart and iTick_1HZ in the same cycle -> iSegundos_Restantes=DRAIN_S, not DRAIN_S-1; a second iStart mid-run is ignored.

Source files
------------

// File: rtl/centrifugado_ejecutor_if.sv
// Control and status bundle between the wash-cycle control FSM and the spin-phase executor.
interface centrifugado_ejecutor_if;
    logic       iTick_1HZ;
    logic       iStart;
    logic       iPausa;
    logic       iHabilitar;
    logic       iCentri_1;
    logic       iCentri_2;
    logic       iCentri_3;
    logic       iCentri_4;
    logic       iLed_Vaceando;
    logic       iLed_Motor;
    logic       iCentri_Activo;
    logic       iCentri_Fin;
    logic       iSel_Error;
    logic [8:0] iSegundos_Restantes;

    modport master (
        output iTick_1HZ, iStart, iPausa, iHabilitar,
               iCentri_1, iCentri_2, iCentri_3, iCentri_4,
        input  iLed_Vaceando, iLed_Motor, iCentri_Activo, iCentri_Fin,
               iSel_Error, iSegundos_Restantes
    );

    modport slave (
        input  iTick_1HZ, iStart, iPausa, iHabilitar,
               iCentri_1, iCentri_2, iCentri_3, iCentri_4,
        output iLed_Vaceando, iLed_Motor, iCentri_Activo, iCentri_Fin,
               iSel_Error, iSegundos_Restantes
    );
endinterface

// File: rtl/centrifugado_ejecutor.sv
// Spin-phase executor: drains the drum, spins for the latched duration, then pulses completion.
// States: IDLE wait for start | VACIANDO drain | CENTRIFUGANDO spin | FIN one-cycle done
module centrifugado_ejecutor #(
    parameter int DRAIN_S = 10,
    parameter int T1_S    = 150,
    parameter int T2_S    = 200,
    parameter int T3_S    = 275,
    parameter int T4_S    = 375
) (
    input  logic                        clk_in,
    input  logic                        iReset,
    centrifugado_ejecutor_if.slave      bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_VAC  = 2'd1;
    localparam logic [1:0] S_CEN  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0] r_state;
    logic [8:0] r_rem;
    logic [8:0] r_dur;
    logic       r_err;

    logic [3:0] w_sel;
    logic       w_onehot;
    logic [8:0] w_dur_sel;
    logic       w_count;

    assign w_sel    = {bus.iCentri_4, bus.iCentri_3, bus.iCentri_2, bus.iCentri_1};
    assign w_onehot = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);
    // Paused ticks are dropped outright rather than remembered.
    assign w_count  = bus.iTick_1HZ && !bus.iPausa;

    always_comb begin
        w_dur_sel = 9'(T1_S);
        case (w_sel)
            4'b0010: w_dur_sel = 9'(T2_S);
            4'b0100: w_dur_sel = 9'(T3_S);
            4'b1000: w_dur_sel = 9'(T4_S);
            default: w_dur_sel = 9'(T1_S);
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (iReset) begin
            r_state <= S_IDLE;
            r_rem   <= 9'd0;
            r_dur   <= 9'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (!bus.iHabilitar && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_rem   <= 9'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.iStart && bus.iHabilitar) begin
                            if (w_onehot) begin
                                r_dur   <= w_dur_sel;
                                r_rem   <= 9'(DRAIN_S);
                                r_state <= S_VAC;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_VAC: begin
                        if (w_count) begin
                            if (r_rem > 9'd1) begin
                                r_rem <= r_rem - 9'd1;
                            end else begin
                                r_rem   <= r_dur;
                                r_state <= S_CEN;
                            end
                        end
                    end
                    S_CEN: begin
                        if (w_count) begin
                            if (r_rem > 9'd1) begin
                                r_rem <= r_rem - 9'd1;
                            end else begin
                                r_rem   <= 9'd0;
                                r_state <= S_FIN;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_rem   <= 9'd0;
                    end
                endcase
            end
        end
    end

    assign bus.iLed_Vaceando       = (r_state == S_VAC);
    assign bus.iLed_Motor          = (r_state == S_CEN) && !bus.iPausa;
    assign bus.iCentri_Activo      = (r_state != S_IDLE);
    assign bus.iCentri_Fin         = (r_state == S_FIN);
    assign bus.iSel_Error          = r_err;
    assign bus.iSegundos_Restantes = r_rem;
endmodule

// File: tb/tb_centrifugado_ejecutor.sv
// Vector table plus scoreboard queue for the spin-phase executor, short drain and T1 overrides.
module tb_centrifugado_ejecutor;
    localparam int DRAIN = 3;
    localparam int T1    = 5;

    typedef struct {
        string      name;
        bit         rst, st, tk, pa, ha;
        logic [3:0] sel;
        logic [8:0] e_rem;
        bit         e_vac, e_mot, e_act, e_fin, e_err;
        int         idle;
    } vec_t;

    logic clk_in = 1'b0;
    logic iReset = 1'b1;
    centrifugado_ejecutor_if bus ();

    centrifugado_ejecutor #(.DRAIN_S(DRAIN), .T1_S(T1)) dut (
        .clk_in (clk_in),
        .iReset (iReset),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t v(string n, bit rst, bit st, bit tk, bit pa, bit ha, logic [3:0] sel,
                               int rem, bit vac, bit mot, bit act, bit fin, bit err, int idle);
        vec_t r;
        r.name = n; r.rst = rst; r.st = st; r.tk = tk; r.pa = pa; r.ha = ha; r.sel = sel;
        r.e_rem = 9'(rem); r.e_vac = vac; r.e_mot = mot; r.e_act = act; r.e_fin = fin; r.e_err = err;
        r.idle = idle;
        return r;
    endfunction

    task automatic drive(bit rst, bit st, bit tk, bit pa, bit ha, logic [3:0] sel);
        iReset         = rst;
        bus.iStart     = st;
        bus.iTick_1HZ  = tk;
        bus.iPausa     = pa;
        bus.iHabilitar = ha;
        {bus.iCentri_4, bus.iCentri_3, bus.iCentri_2, bus.iCentri_1} = sel;
    endtask

    task automatic apply(vec_t x);
        vec_t e;
        logic [13:0] got, want;
        @(negedge clk_in);
        drive(x.rst, x.st, x.tk, x.pa, x.ha, x.sel);
        exp_q.push_back(x);
        @(posedge clk_in);
        #1;
        e    = exp_q.pop_front();
        got  = {bus.iSegundos_Restantes, bus.iLed_Vaceando, bus.iLed_Motor,
                bus.iCentri_Activo, bus.iCentri_Fin, bus.iSel_Error};
        want = {e.e_rem, e.e_vac, e.e_mot, e.e_act, e.e_fin, e.e_err};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got rem=%0d vac/mot/act/fin/err=%b, want rem=%0d vac/mot/act/fin/err=%b",
                     e.name, got[13:5], got[4:0], want[13:5], want[4:0]);
        end
        for (int i = 0; i < x.idle; i++) begin
            @(negedge clk_in);
            drive(1'b0, 1'b0, 1'b0, x.pa, x.ha, x.sel);
        end
    endtask

    task automatic check(string n, int got, int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", n, got, want);
        end
    endtask

    initial begin
        int  cyc;
        bit  fin_seen;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);

        // name           rst st tk pa ha sel       rem vac mot act fin err idle
        vecs.push_back(v("reset",      1,0,0,0,1,4'b0001,   0,0,0,0,0,0, 2));
        vecs.push_back(v("startA",     0,1,0,0,1,4'b0001,   3,1,0,1,0,0, 9));
        vecs.push_back(v("drainA2",    0,0,1,0,1,4'b0001,   2,1,0,1,0,0, 9));
        vecs.push_back(v("drainA1",    0,0,1,0,1,4'b0001,   1,1,0,1,0,0, 9));
        vecs.push_back(v("spinA5",     0,0,1,0,1,4'b0001,   5,0,1,1,0,0, 9));
        vecs.push_back(v("spinA4",     0,0,1,0,1,4'b0001,   4,0,1,1,0,0, 9));
        vecs.push_back(v("spinA3",     0,0,1,0,1,4'b0001,   3,0,1,1,0,0, 9));
        vecs.push_back(v("spinA2",     0,0,1,0,1,4'b0001,   2,0,1,1,0,0, 9));
        vecs.push_back(v("spinA1",     0,0,1,0,1,4'b0001,   1,0,1,1,0,0, 9));
        vecs.push_back(v("finA",       0,0,1,0,1,4'b0001,   0,0,0,1,1,0, 0));
        vecs.push_back(v("idleA",      0,0,0,0,1,4'b0001,   0,0,0,0,0,0, 2));
        vecs.push_back(v("err0000",    0,1,0,0,1,4'b0000,   0,0,0,0,0,1, 0));
        vecs.push_back(v("errclr0",    0,0,0,0,1,4'b0000,   0,0,0,0,0,0, 0));
        vecs.push_back(v("err0110",    0,1,0,0,1,4'b0110,   0,0,0,0,0,1, 0));
        vecs.push_back(v("errclr1",    0,0,0,0,1,4'b0110,   0,0,0,0,0,0, 0));
        vecs.push_back(v("hab0start",  0,1,0,0,0,4'b0001,   0,0,0,0,0,0, 2));
        vecs.push_back(v("starttick",  0,1,1,0,1,4'b0001,   3,1,0,1,0,0, 3));
        vecs.push_back(v("stB2",       0,0,1,0,1,4'b0001,   2,1,0,1,0,0, 3));
        vecs.push_back(v("restart",    0,1,0,0,1,4'b0001,   2,1,0,1,0,0, 3));
        vecs.push_back(v("stB1",       0,0,1,0,1,4'b0001,   1,1,0,1,0,0, 3));
        vecs.push_back(v("spB5",       0,0,1,0,1,4'b0001,   5,0,1,1,0,0, 3));
        vecs.push_back(v("spB4",       0,0,1,0,1,4'b0001,   4,0,1,1,0,0, 3));
        for (int i = 0; i < 6; i++)
            vecs.push_back(v("pause",  0,0,1,1,1,4'b0001,   4,0,0,1,0,0, 3));
        vecs.push_back(v("resume",     0,0,0,0,1,4'b0001,   4,0,1,1,0,0, 3));
        vecs.push_back(v("spB3",       0,0,1,0,1,4'b0001,   3,0,1,1,0,0, 3));
        vecs.push_back(v("spB2",       0,0,1,0,1,4'b0001,   2,0,1,1,0,0, 3));
        vecs.push_back(v("abortB",     0,0,0,0,0,4'b0001,   0,0,0,0,0,0, 0));
        vecs.push_back(v("abortnofin", 0,0,0,0,1,4'b0001,   0,0,0,0,0,0, 2));
        vecs.push_back(v("startR",     0,1,0,0,1,4'b0001,   3,1,0,1,0,0, 3));
        vecs.push_back(v("vacpause",   0,0,1,1,1,4'b0001,   3,1,0,1,0,0, 3));
        vecs.push_back(v("vacR2",      0,0,1,0,1,4'b0001,   2,1,0,1,0,0, 3));
        vecs.push_back(v("rsthab0",    1,0,0,0,0,4'b0001,   0,0,0,0,0,0, 0));
        vecs.push_back(v("afterrst",   0,0,0,0,1,4'b0001,   0,0,0,0,0,0, 2));
        vecs.push_back(v("start3",     0,1,0,0,1,4'b0100,   3,1,0,1,0,0, 3));
        vecs.push_back(v("s3d2sel",    0,0,1,0,1,4'b0001,   2,1,0,1,0,0, 3));
        vecs.push_back(v("s3d1",       0,0,1,0,1,4'b0001,   1,1,0,1,0,0, 3));
        vecs.push_back(v("s3c275",     0,0,1,0,1,4'b0001, 275,0,1,1,0,0, 3));
        vecs.push_back(v("s3c274",     0,0,1,0,1,4'b0001, 274,0,1,1,0,0, 3));
        vecs.push_back(v("abort3",     0,0,0,0,0,4'b0001,   0,0,0,0,0,0, 0));
        vecs.push_back(v("start4",     0,1,0,0,1,4'b1000,   3,1,0,1,0,0, 1));
        vecs.push_back(v("s4d2",       0,0,1,0,1,4'b1000,   2,1,0,1,0,0, 1));
        vecs.push_back(v("s4d1",       0,0,1,0,1,4'b1000,   1,1,0,1,0,0, 1));
        vecs.push_back(v("s4c375",     0,0,1,0,1,4'b1000, 375,0,1,1,0,0, 1));
        vecs.push_back(v("abort4",     0,0,0,0,0,4'b1000,   0,0,0,0,0,0, 0));
        vecs.push_back(v("start2",     0,1,0,0,1,4'b0010,   3,1,0,1,0,0, 1));
        vecs.push_back(v("s2d2",       0,0,1,0,1,4'b0010,   2,1,0,1,0,0, 1));
        vecs.push_back(v("s2d1",       0,0,1,0,1,4'b0010,   1,1,0,1,0,0, 1));
        vecs.push_back(v("s2c200",     0,0,1,0,1,4'b0010, 200,0,1,1,0,0, 1));
        vecs.push_back(v("rst2",       1,0,0,0,1,4'b0010,   0,0,0,0,0,0, 1));

        foreach (vecs[i]) apply(vecs[i]);

        // Continuous ticks: FIN must appear after exactly DRAIN+T1 counting edges, for one cycle.
        @(negedge clk_in);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001);
        @(negedge clk_in);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001);
        cyc = 0;
        fin_seen = 0;
        while (!fin_seen && cyc < 60) begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (bus.iCentri_Fin) fin_seen = 1;
        end
        check("fin_seen", int'(fin_seen), 1);
        check("run_ticks", cyc, DRAIN + T1);
        @(negedge clk_in);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
        @(posedge clk_in);
        #1;
        check("fin_one_cycle", int'(bus.iCentri_Fin), 0);
        check("idle_after_fin", int'(bus.iCentri_Activo), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
